// File: rtl/crc_bus_master.sv
// Bus initiator for the CRC block: programs poly/seed, streams job words into DATA,
// reads the CRC back and presents it on a valid/ready result port.
module crc_bus_master #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_poly,
    input  logic [31:0]      cmd_seed,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_crc,
    output logic             busy,
    output logic [31:0]      addr,
    output logic [31:0]      data_wr,
    output logic             RW,
    output logic             Sel,
    input  logic [31:0]      data_rd
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] W_POLY  = 4'd1;
    localparam logic [3:0] W_CTRL1 = 4'd2;
    localparam logic [3:0] W_SEED  = 4'd3;
    localparam logic [3:0] W_CTRL0 = 4'd4;
    localparam logic [3:0] STREAM  = 4'd5;
    localparam logic [3:0] RD_REQ  = 4'd6;
    localparam logic [3:0] RD_WAIT = 4'd7;
    localparam logic [3:0] RESULT  = 4'd8;

    localparam logic [31:0] OFF_DATA = 32'h0;
    localparam logic [31:0] OFF_POLY = 32'h4;
    localparam logic [31:0] OFF_CTRL = 32'h8;

    localparam int unsigned    LAT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [LAT_W-1:0] LAT_END = RD_LAT[LAT_W-1:0];

    logic [3:0]       state_q, state_d;
    logic [31:0]      seed_q, seed_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_wr_q, data_wr_d;
    logic             rw_q, rw_d;
    logic             sel_q, sel_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_crc_q, res_crc_d;

    logic cmd_fire;
    logic s_fire;
    logic res_fire;
    logic in_stream;

    // The state names the bus access visible in the current cycle; W_CTRL0 already
    // behaves as the first streaming cycle so the first word can be taken in cycle 4.
    assign in_stream = (state_q == W_CTRL0) || (state_q == STREAM);
    assign s_ready   = in_stream && (rem_q != '0);
    assign s_fire    = s_valid && s_ready;
    assign cmd_fire  = cmd_valid && cmd_ready_q;
    assign res_fire  = res_valid_q && res_ready;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        rem_d       = rem_q;
        lat_d       = lat_q;
        res_valid_d = res_valid_q;
        res_crc_d   = res_crc_q;
        sel_d       = 1'b0;
        rw_d        = 1'b0;
        addr_d      = '0;
        data_wr_d   = '0;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    seed_d    = cmd_seed;
                    rem_d     = cmd_len;
                    sel_d     = 1'b1;
                    rw_d      = 1'b1;
                    addr_d    = BASE_ADDR + OFF_POLY;
                    data_wr_d = cmd_poly;
                    state_d   = W_POLY;
                end
            end
            W_POLY: begin
                sel_d     = 1'b1;
                rw_d      = 1'b1;
                addr_d    = BASE_ADDR + OFF_CTRL;
                data_wr_d = 32'h1;
                state_d   = W_CTRL1;
            end
            W_CTRL1: begin
                sel_d     = 1'b1;
                rw_d      = 1'b1;
                addr_d    = BASE_ADDR + OFF_DATA;
                data_wr_d = seed_q;
                state_d   = W_SEED;
            end
            W_SEED: begin
                sel_d     = 1'b1;
                rw_d      = 1'b1;
                addr_d    = BASE_ADDR + OFF_CTRL;
                data_wr_d = 32'h0;
                state_d   = W_CTRL0;
            end
            W_CTRL0, STREAM: begin
                if (rem_q == '0) begin
                    sel_d   = 1'b1;
                    addr_d  = BASE_ADDR + OFF_DATA;
                    state_d = RD_REQ;
                end else begin
                    state_d = STREAM;
                    if (s_fire) begin
                        sel_d     = 1'b1;
                        rw_d      = 1'b1;
                        addr_d    = BASE_ADDR + OFF_DATA;
                        data_wr_d = s_data;
                        rem_d     = rem_q - CNT_ONE;
                    end
                end
            end
            RD_REQ: begin
                lat_d   = 3'd1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_q == LAT_END) begin
                    res_crc_d   = data_rd;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RESULT: begin
                if (res_fire) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            rem_q       <= '0;
            lat_q       <= '0;
            addr_q      <= '0;
            data_wr_q   <= '0;
            rw_q        <= 1'b0;
            sel_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_crc_q   <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            rem_q       <= rem_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            data_wr_q   <= data_wr_d;
            rw_q        <= rw_d;
            sel_q       <= sel_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_crc   = res_crc_q;
    assign addr      = addr_q;
    assign data_wr   = data_wr_q;
    assign RW        = rw_q;
    assign Sel       = sel_q;

endmodule
